uart_rx_frontend: RTL and testbench

- Serial receive front end inside tt_um_tyt33. It sits directly downstream of the top-level pins: it consumes one bit of ui_in (the RX line) and feeds bytes to the project core.
- Receives 8N1 asynchronous frames, LSB first.
- Presents each byte through a one-entry valid/ready holding register.
- Keeps sticky framing and overrun flags, which the core can clear.

---
 rtl/uart_rx_frontend.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_frontend.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frontend.sv
// 8N1 serial receiver front end: two-flop synchronizer, mid-bit sampling FSM,
// one-entry valid/ready holding register and sticky framing/overrun flags.
module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync_reg;
  logic             rx_s;
  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             deliver_reg;
  logic [7:0]       rx_data_reg;
  logic             rx_valid_reg;
  logic             frame_err_reg;
  logic             overrun_reg;
  logic             busy_reg;

  // Reset to the idle (high) level so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx_in};
    end
  end

  assign rx_s = sync_reg[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      deliver_reg   <= 1'b0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      deliver_reg <= 1'b0;

      // Later assignments below override these, so a set beats a clear.
      if (err_clr) begin
        frame_err_reg <= 1'b0;
        overrun_reg   <= 1'b0;
      end

      if (rx_valid_reg && rx_ready) begin
        rx_valid_reg <= 1'b0;
      end

      // Delivery happens one edge after the good stop sample.
      if (deliver_reg) begin
        if (!rx_valid_reg || rx_ready) begin
          rx_data_reg  <= shift_reg;
          rx_valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end

      if (!ena) begin
        state_reg   <= IDLE;
        cnt_reg     <= '0;
        bit_idx_reg <= '0;
        busy_reg    <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (!rx_s) begin
              state_reg <= START;
              cnt_reg   <= '0;
              busy_reg  <= 1'b1;
            end
          end

          START: begin
            if (cnt_reg == CNT_HALF) begin
              cnt_reg     <= '0;
              bit_idx_reg <= '0;
              if (rx_s) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
              end else begin
                state_reg <= DATA;
              end
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end

          DATA: begin
            if (cnt_reg == CNT_LAST) begin
              cnt_reg     <= '0;
              shift_reg   <= {rx_s, shift_reg[7:1]};
              bit_idx_reg <= bit_idx_reg + 3'd1;
              if (bit_idx_reg == 3'd7) begin
                state_reg <= STOP;
              end
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end

          STOP: begin
            if (cnt_reg == CNT_LAST) begin
              cnt_reg <= '0;
              if (rx_s) begin
                state_reg   <= IDLE;
                busy_reg    <= 1'b0;
                deliver_reg <= 1'b1;
              end else begin
                state_reg     <= WAIT_IDLE;
                frame_err_reg <= 1'b1;
              end
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end

          WAIT_IDLE: begin
            if (rx_s) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end

          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed + randomized bench for uart_rx_frontend at CLKS_PER_BIT=8; expected
// outputs come from a holding-register model updated at frame boundaries.
module tb_uart_rx_frontend;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       rx_in = 1'b1;
  logic       rx_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad = 0;

  // Reference model of the byte-facing state.
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_ovr = 1'b0;
  logic       m_ferr = 1'b0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  bit         mon_en = 1'b0;

  always #5 clk = ~clk;

  uart_rx_frontend #(.CLKS_PER_BIT(N), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .rx_in    (rx_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .err_clr  (err_clr),
    .busy     (busy)
  );

  always @(negedge clk) begin
    if (mon_en && rx_valid && rx_ready) got_q.push_back(rx_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " rx_valid"}, {31'd0, rx_valid}, {31'd0, m_valid});
    if (m_valid) check({tag, " rx_data"}, {24'd0, rx_data}, {24'd0, m_data});
    check({tag, " overrun"}, {31'd0, overrun}, {31'd0, m_ovr});
    check({tag, " frame_err"}, {31'd0, frame_err}, {31'd0, m_ferr});
  endtask

  // Byte arrives at the holding register; accepted_now means the core takes
  // the old byte on the same edge.
  task automatic model_deliver(input logic [7:0] b, input bit accepted_now);
    if (!m_valid || accepted_now) begin
      m_data  = b;
      m_valid = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  // Drives start, 8 data bits LSB first, then the stop level; stops early
  // after 'limit' bit-cycles. Returns on the negedge of the last drive.
  task automatic drive_frame(input logic [7:0] b, input int stop_cycles,
                             input logic stop_val, input int limit);
    logic [9:0] bits;
    int k;
    int len;
    bits = {stop_val, b, 1'b0};
    k = 0;
    $display("frame 0x%02h stop=%0d/%0d limit=%0d", b, stop_val, stop_cycles, limit);
    for (int i = 0; i < 10; i++) begin
      len = (i == 9) ? stop_cycles : N;
      for (int c = 0; c < len; c++) begin
        if (k >= limit) return;
        @(negedge clk);
        rx_in = bits[i];
        k++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_in = 1'b1;
    end
  endtask

  task automatic accept();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    m_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    int gap;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset rx_data", {24'd0, rx_data}, 32'h0);
    check("reset rx_valid", {31'd0, rx_valid}, 32'h0);
    check("reset frame_err", {31'd0, frame_err}, 32'h0);
    check("reset overrun", {31'd0, overrun}, 32'h0);
    check("reset busy", {31'd0, busy}, 32'h0);
    rst_n = 1'b1;
    ena = 1'b1;
    idle(4);

    // 1: basic frame, latency, hold and accept
    drive_frame(8'h5A, N, 1'b1, 1000);
    check("t1 before delivery", {31'd0, rx_valid}, 32'h0);
    @(negedge clk);
    model_deliver(8'h5A, 1'b0);
    check_model("t1 delivered");
    check("t1 busy after", {31'd0, busy}, 32'h0);
    repeat (20) @(negedge clk);
    check_model("t1 hold");
    accept();
    check_model("t1 accepted");

    // 2: short glitch is a false start
    @(negedge clk); rx_in = 1'b0;
    @(negedge clk);
    @(negedge clk); rx_in = 1'b1;
    @(negedge clk);
    check("t2 busy during start", {31'd0, busy}, 32'h1);
    repeat (4) @(negedge clk);
    check("t2 busy after false start", {31'd0, busy}, 32'h0);
    idle(100);
    check_model("t2 no byte");

    // 3: overrun, clear, then consume on the delivery edge
    drive_frame(8'h11, N, 1'b1, 1000);
    drive_frame(8'h22, N, 1'b1, 1000);
    @(negedge clk);
    model_deliver(8'h11, 1'b0);
    model_deliver(8'h22, 1'b0);
    check_model("t3 overrun");
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_ovr = 1'b0;
    check_model("t3 cleared");
    drive_frame(8'h22, N, 1'b1, 1000);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    model_deliver(8'h22, 1'b1);
    check_model("t3 same-edge accept");
    accept();

    // 4: framing error with line stuck low, then recovery
    drive_frame(8'hA5, 30, 1'b0, 1000);
    m_ferr = 1'b1;
    check_model("t4 frame_err");
    check("t4 busy stuck low", {31'd0, busy}, 32'h1);
    idle(1);
    check("t4 busy wait", {31'd0, busy}, 32'h1);
    idle(3);
    check("t4 busy released", {31'd0, busy}, 32'h0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_ferr = 1'b0;
    check_model("t4 err cleared");
    drive_frame(8'h3C, N, 1'b1, 1000);
    @(negedge clk);
    model_deliver(8'h3C, 1'b0);
    check_model("t4 next frame");
    accept();

    // 5: ena abort during data bit 3, then async reset mid-frame
    drive_frame(8'hC3, N, 1'b1, 36);
    check("t5 busy before abort", {31'd0, busy}, 32'h1);
    @(negedge clk);
    ena = 1'b0;
    rx_in = 1'b1;
    @(negedge clk);
    check("t5 busy after abort", {31'd0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    ena = 1'b1;
    idle(12);
    check_model("t5 nothing delivered");
    drive_frame(8'hFF, N, 1'b1, 1000);
    @(negedge clk);
    model_deliver(8'hFF, 1'b0);
    check_model("t5 after ena");
    drive_frame(8'h96, N, 1'b1, 20);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5 async rx_data", {24'd0, rx_data}, 32'h0);
    check("t5 async rx_valid", {31'd0, rx_valid}, 32'h0);
    check("t5 async busy", {31'd0, busy}, 32'h0);
    check("t5 async flags", {30'd0, frame_err, overrun}, 32'h0);
    m_valid = 1'b0;
    m_data = 8'h00;
    rx_in = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    // 6: back-to-back fixed frames plus random frames with random gaps
    rx_ready = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) b = 8'h00;
      else if (i == 1) b = 8'h80;
      else if (i == 2) b = 8'h01;
      else b = 8'($urandom_range(0, 255));
      gap = (i < 3) ? 0 : int'($urandom_range(0, 3));
      exp_q.push_back(b);
      drive_frame(b, N, 1'b1, 1000);
      if (gap > 0) idle(gap);
    end
    idle(4);
    rx_ready = 1'b0;
    mon_en = 1'b0;
    check("t6 count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("t6 byte%0d", i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    end
    check_model("t6 end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
